// File: rtl/shake_pkg.sv
// Shared constants, FSM state type and helpers for the SHAKE XOF output path.
package shake_pkg;

  localparam int unsigned SHAKE256_RATE = 1088;
  localparam int unsigned SHAKE128_RATE = 1344;
  localparam int unsigned DEFAULT_OUT_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_BLK,
    EMIT,
    DONE
  } state_e;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/shake_blk_unload.sv
// Holds one squeeze block and unloads it MSB-first, OUT_W bits per shift.
module shake_blk_unload #(
  parameter int unsigned RATE  = 1088,
  parameter int unsigned OUT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [RATE-1:0]  load_data,
  input  logic             shift,
  output logic [OUT_W-1:0] top_word,
  output logic             blk_empty,
  output logic             blk_last
);

  localparam int unsigned NWORDS = RATE / OUT_W;
  localparam int unsigned IDX_W  = $clog2(NWORDS + 1);

  logic [RATE-1:0]  sr_q, sr_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;

  // Shift register and word counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      word_idx_q <= '0;
    end else begin
      sr_q       <= sr_d;
      word_idx_q <= word_idx_d;
    end
  end

  // Load takes priority; each shift exposes the next lower word at the top
  always_comb begin
    sr_d       = sr_q;
    word_idx_d = word_idx_q;
    if (load) begin
      sr_d       = load_data;
      word_idx_d = '0;
    end else if (shift) begin
      sr_d       = sr_q << OUT_W;
      word_idx_d = word_idx_q + IDX_W'(1);
    end
  end

  assign top_word  = sr_q[RATE-1 -: OUT_W];
  assign blk_empty = (word_idx_q == IDX_W'(NWORDS));
  // Word currently on top is the final one of this block
  assign blk_last  = (word_idx_q == IDX_W'(NWORDS - 1));

endmodule

// File: rtl/shake_xof_truncator.sv
// Streams an out_len-bit SHAKE XOF digest as MSB-first words, pulling
// squeeze blocks on demand and zeroing the unused tail of the final word.
module shake_xof_truncator
  import shake_pkg::*;
#(
  parameter int unsigned RATE  = SHAKE256_RATE,
  parameter int unsigned OUT_W = DEFAULT_OUT_W,
  parameter int unsigned MAX_L = 4096,
  parameter int unsigned LEN_W = $clog2(MAX_L + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEN_W-1:0]             out_len,
  output logic                         busy,
  output logic                         squeeze_req,
  input  logic                         blk_valid,
  output logic                         blk_ready,
  input  logic [RATE-1:0]              blk_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [$clog2(OUT_W+1)-1:0]   out_nbits,
  output logic                         out_last,
  output logic                         done
);

  localparam int unsigned NB_W = $clog2(OUT_W + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_clamped;
  logic [NB_W-1:0]  nbits_w;
  logic [OUT_W-1:0] keep_mask;
  logic [OUT_W-1:0] top_word;
  logic             last_w;
  logic             blk_empty, blk_last;
  logic             load, shift;

  shake_blk_unload #(
    .RATE  (RATE),
    .OUT_W (OUT_W)
  ) u_unload (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (blk_data),
    .shift     (shift),
    .top_word  (top_word),
    .blk_empty (blk_empty),
    .blk_last  (blk_last)
  );

  assign len_clamped = LEN_W'(min_u(32'(out_len), MAX_L));
  assign nbits_w     = NB_W'(min_u(32'(rem_q), OUT_W));
  assign last_w      = (32'(rem_q) <= OUT_W);
  // Ones in the top nbits_w positions; a full word shifts everything out
  assign keep_mask   = ~({OUT_W{1'b1}} >> nbits_w);

  // FSM state and remaining-bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state and outputs; reset masks every output in its own cycle so an
  // abort issues nothing further
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    busy        = 1'b0;
    squeeze_req = 1'b0;
    blk_ready   = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_nbits   = '0;
    out_last    = 1'b0;
    done        = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    if (!reset) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (start) begin
            busy    = 1'b1;
            rem_d   = len_clamped;
            state_d = (len_clamped == '0) ? DONE : REQ;
          end
        end
        REQ: begin
          squeeze_req = 1'b1;
          state_d     = WAIT_BLK;
        end
        WAIT_BLK: begin
          blk_ready = 1'b1;
          if (blk_valid) begin
            load    = 1'b1;
            state_d = EMIT;
          end
        end
        EMIT: begin
          out_valid = 1'b1;
          out_data  = top_word & keep_mask;
          out_nbits = nbits_w;
          out_last  = last_w;
          if (out_ready) begin
            shift = ~blk_empty;
            rem_d = rem_q - LEN_W'(nbits_w);
            if (last_w)        state_d = DONE;
            else if (blk_last) state_d = REQ;
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/shake_xof_truncator.md
Name: shake_xof_truncator

Overview:
Parametrised successor to the fixed 256-bit digest truncator. It produces an arbitrary-length SHAKE256 XOF output of `out_len` bits, up to MAX_L. It pulls as many rate blocks from the squeeze stage as needed, requesting each one with `squeeze_req`, and streams the digest MSB-first as OUT_W-bit words on a valid/ready interface. It sits between the squeeze module and the output FIFO/host bus, under control-unit start/done.

Parameters:
- RATE, 1088, squeeze block width in bits. Must be a multiple of OUT_W.
- OUT_W, 64, output word width in bits.
- MAX_L, 4096, maximum digest length in bits. Longer requests are clamped.
- LEN_W, $clog2(MAX_L+1), width of length fields.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle start pulse from the control unit
- out_len  in  LEN_W  requested digest length in bits; sampled on accepted start
- busy  out  1  high from accepted start until the done cycle, inclusive
- squeeze_req  out  1  one-cycle pulse requesting the next squeeze block
- blk_valid  in  1  squeeze block available
- blk_ready  out  1  truncator can accept a block
- blk_data  in  RATE  squeeze block (Z)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  OUT_W  digest word, MSB-aligned
- out_nbits  out  $clog2(OUT_W+1)  number of valid MSBs in out_data
- out_last  out  1  final word of the digest
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers cleared. Reset mid-operation aborts immediately. No further `squeeze_req` or words are issued, and no `done` pulse is generated.
- State IDLE:
  - start=1 latches `rem = min(out_len, MAX_L)`.
  - If rem=0, go to DONE. Otherwise go to REQ.
  - start while not IDLE is ignored.
- State REQ (1 cycle): `squeeze_req=1`, then go to WAIT_BLK. Every block, including the first, is requested exactly once.
- State WAIT_BLK:
  - `blk_ready=1`.
  - On blk_valid & blk_ready: load blk_data into the unload shift register, set `word_idx=0`, go to EMIT.
  - `blk_ready` is 0 in every other state.
- State EMIT:
  - `out_valid=1`.
  - `out_data` = shift-register top OUT_W bits, i.e. word k = Z[RATE-1-k*OUT_W -: OUT_W]. This keeps the top-slice ordering of the legacy truncator.
  - `out_nbits = min(rem, OUT_W)`. Bits below `out_nbits` are forced to 0.
  - `out_last = (rem <= OUT_W)`.
  - Outputs are held stable while out_ready=0.
  - On handshake:
    - rem -= out_nbits; shift left by OUT_W; word_idx++.
    - If out_last, go to DONE.
    - Else if word_idx reaches RATE/OUT_W, go to REQ.
    - Else stay in EMIT.
- State DONE (1 cycle): `done=1`, `busy=1`, then go to IDLE.
- Latency:
  - start to squeeze_req: 2 cycles (start cycle, IDLE→REQ).
  - Block accept to first out_valid: 1 cycle.
  - Back-to-back words with out_ready held high: 1 word/cycle.
- Boundaries:
  - rem an exact multiple of RATE: no extra block is requested after the final word.
  - out_len > MAX_L: clamped to MAX_L.
  - blk_valid outside WAIT_BLK: ignored (not consumed).
  - start and reset in the same cycle: reset wins.

Decomposition:
- Package `shake_pkg`:
  - constants SHAKE256_RATE=1088, SHAKE128_RATE=1344.
  - default OUT_W.
  - state enum {IDLE, REQ, WAIT_BLK, EMIT, DONE}.
  - a `min` helper function.
- Sub-module `shake_blk_unload`:
  - RATE-bit load/shift-left-by-OUT_W register with word counter.
  - Outputs: top word and `blk_empty` (word_idx == RATE/OUT_W).
- The FSM and length accounting stay in `shake_xof_truncator`.

Test Plan:
- out_len=256, one block Z with known pattern, out_ready=1 → exactly 1 squeeze_req; 4 words equal Z[1087:832] split MSB-first; last word nbits=64, out_last=1; done 1 cycle after the 4th handshake.
- out_len=0 → no squeeze_req, no out_valid; done pulses 2 cycles after start; busy high for those 2 cycles.
- out_len=1088 → 17 words, exactly 1 squeeze_req, last word = Z[63:0] with out_last=1.
- out_len=1100 → 2 squeeze_reqs, 18 words; word 18 = top 12 bits of block 2, low 52 bits zero, nbits=12.
- Random out_ready backpressure on out_len=300 → out_data/out_nbits/out_last stable while stalled; 5 words, final nbits=44; start pulse issued mid-run is ignored.
- Reset asserted during EMIT of word 3 with out_len=4096 → next cycle all outputs 0, state IDLE, no done; a subsequent out_len=5000 run is clamped to 4096 (4 blocks, 64 words).
